// File: rtl/exe_div_ctrl_pkg.sv
// Shared definitions for the EXE-stage divide sequencer.
// State encodings, step count and the DS->ES divide op field.
package exe_div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_st_e;

    localparam int DIV_STEPS = 32;

    // Carried on the DS->ES bus so DS can mark divide instructions
    typedef struct packed {
        logic div;
        logic sgn;
    } div_op_t;

endpackage

// File: rtl/exe_div_ctrl_if.sv
// Handshake/data bundle between the EXE datapath and the divider.
// master = EXE stage, slave = divide sequencer.
interface exe_div_ctrl_if
    import exe_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS
);
    logic             div_req;
    logic             div_signed;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             es_fire;
    logic             es_flush;
    logic             div_busy;
    logic             div_ready_go;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    modport master (
        output div_req, div_signed, div_src1, div_src2,
        output es_fire, es_flush,
        input  div_busy, div_ready_go, div_quot, div_rem
    );

    modport slave (
        input  div_req, div_signed, div_src1, div_src2,
        input  es_fire, es_flush,
        output div_busy, div_ready_go, div_quot, div_rem
    );
endinterface

// File: rtl/exe_div_ctrl_div_step.sv
// One combinational restoring-division step:
// shift {rem,dvd} left, subtract divisor if it fits.
module exe_div_ctrl_div_step
    import exe_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);
    // Shifted remainder needs one extra bit before the compare
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sh    = {rem_i, dvd_i[WIDTH-1]};
        diff  = sh - {1'b0, dsr_i};
        ge    = (sh >= {1'b0, dsr_i});
        rem_o = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        dvd_o = {dvd_i[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/exe_div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for EXE.
// Holds ready_go low while computing, then presents quot/rem.
module exe_div_ctrl
    import exe_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS,
    parameter int CNT_W = 6
) (
    input logic             clk,
    input logic             reset,
    exe_div_ctrl_if.slave   div_if
);
    div_st_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] reso_q, reso_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH-1:0] rem_s, dvd_s;
    logic [WIDTH-1:0] abs1, abs2;
    logic             msb1, msb2;

    exe_div_ctrl_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (rem_s),
        .dvd_o (dvd_s)
    );

    assign msb1 = div_if.div_src1[WIDTH-1];
    assign msb2 = div_if.div_src2[WIDTH-1];
    assign abs1 = (div_if.div_signed && msb1) ? -div_if.div_src1
                                              : div_if.div_src1;
    assign abs2 = (div_if.div_signed && msb2) ? -div_if.div_src2
                                              : div_if.div_src2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quot_d  = quot_q;
        reso_d  = reso_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        unique case (state_q)
            DIV_ST_IDLE: begin
                if (div_if.div_req && !div_if.es_flush) begin
                    dvd_d  = abs1;
                    dsr_d  = abs2;
                    rem_d  = '0;
                    cnt_d  = '0;
                    qneg_d = div_if.div_signed & (msb1 ^ msb2);
                    rneg_d = div_if.div_signed & msb1;
                    if (abs2 == '0) begin
                        state_d = DIV_ST_DONE;
                        quot_d  = '1;
                        reso_d  = div_if.div_src1;
                    end else begin
                        state_d = DIV_ST_CALC;
                    end
                end
            end
            DIV_ST_CALC: begin
                rem_d = rem_s;
                dvd_d = dvd_s;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_ST_DONE;
                    quot_d  = qneg_q ? -dvd_s : dvd_s;
                    reso_d  = rneg_q ? -rem_s : rem_s;
                end
            end
            DIV_ST_DONE: begin
                if (div_if.es_fire) begin
                    state_d = DIV_ST_IDLE;
                    quot_d  = '0;
                    reso_d  = '0;
                end
            end
            default: state_d = DIV_ST_IDLE;
        endcase
        // Flush beats everything but reset
        if (div_if.es_flush) begin
            state_d = DIV_ST_IDLE;
            quot_d  = '0;
            reso_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            reso_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quot_q  <= quot_d;
            reso_q  <= reso_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign div_if.div_busy     = (state_q == DIV_ST_CALC);
    assign div_if.div_ready_go = (state_q == DIV_ST_DONE);
    assign div_if.div_quot     = quot_q;
    assign div_if.div_rem      = reso_q;
endmodule

// File: tb/tb_exe_div_ctrl.sv
// Bench for exe_div_ctrl: vector table, corner sequences,
// and random operands against an arithmetic reference model.
module tb_exe_div_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    exe_div_ctrl_if #(.WIDTH(32)) dif();

    exe_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    function automatic void model(input logic sgn,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
    endfunction

    task automatic issue(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
        dif.div_req    = 1'b1;
        dif.div_signed = sgn;
        dif.div_src1   = a;
        dif.div_src2   = b;
        tick();
        dif.div_req    = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the request edge
    task automatic wait_done(input bit noisy, output int lat);
        lat = 1;
        while (!dif.div_ready_go && lat < 40) begin
            if (noisy) begin
                dif.div_src1   = $urandom;
                dif.div_src2   = $urandom;
                dif.div_signed = 1'($urandom);
                dif.div_req    = 1'($urandom);
                dif.es_fire    = 1'($urandom);
            end
            tick();
            lat++;
        end
        dif.es_fire = 1'b0;
        dif.div_req = 1'b0;
    endtask

    task automatic fire_idle(input string nm);
        dif.es_fire = 1'b1;
        tick();
        dif.es_fire = 1'b0;
        chk({nm, "_idle_busy"}, 32'(dif.div_busy), 32'd0);
        chk({nm, "_idle_rdy"}, 32'(dif.div_ready_go), 32'd0);
    endtask

    task automatic run_chk(input string nm, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit noisy);
        logic [31:0] q, r;
        int lat;
        model(sgn, a, b, q, r);
        issue(sgn, a, b);
        wait_done(noisy, lat);
        chk({nm, "_lat"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
        chk({nm, "_quot"}, dif.div_quot, q);
        chk({nm, "_rem"}, dif.div_rem, r);
    endtask

    initial begin
        vec_t vt[7];
        int lat;
        bit seen;
        logic [31:0] a, b;
        logic sgn;
        int pick;

        vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,
                  32'd2,          33};
        vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,
                  32'hFFFF_FFFF,  33};
        vt[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,
                  32'd1,          33};
        vt[3] = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,
                  32'h1234,       1};
        vt[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,
                  32'd0,          33};
        vt[5] = '{1'b1, 32'hFFFF_FF00,  32'd0,          32'hFFFF_FFFF,
                  32'hFFFF_FF00,  1};
        vt[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,
                  32'd0,          33};

        total = 0;
        bad   = 0;
        reset = 1'b1;
        dif.div_req    = 1'b0;
        dif.div_signed = 1'b0;
        dif.div_src1   = '0;
        dif.div_src2   = '0;
        dif.es_fire    = 1'b0;
        dif.es_flush   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(dif.div_busy), 32'd0);
        chk("rst_rdy", 32'(dif.div_ready_go), 32'd0);
        chk("rst_quot", dif.div_quot, 32'd0);
        chk("rst_rem", dif.div_rem, 32'd0);

        for (int i = 0; i < 7; i++) begin
            issue(vt[i].sgn, vt[i].a, vt[i].b);
            wait_done(1'b0, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_quot", i), dif.div_quot, vt[i].q);
            chk($sformatf("vec%0d_rem", i), dif.div_rem, vt[i].r);
            fire_idle($sformatf("vec%0d", i));
        end

        // Flush mid-calc, then a fresh divide
        seen = 1'b0;
        issue(1'b0, 32'd50, 32'd5);
        for (int c = 1; c < 10; c++) begin
            seen |= dif.div_ready_go;
            tick();
        end
        dif.es_flush = 1'b1;
        tick();
        dif.es_flush = 1'b0;
        chk("flush_busy", 32'(dif.div_busy), 32'd0);
        chk("flush_rdy", 32'(dif.div_ready_go), 32'd0);
        chk("flush_seen", 32'(seen), 32'd0);
        tick();
        run_chk("post_flush", 1'b0, 32'd9, 32'd4, 1'b0);
        fire_idle("post_flush");

        // Flush together with request in IDLE: ignored
        dif.es_flush = 1'b1;
        issue(1'b0, 32'd9, 32'd4);
        dif.es_flush = 1'b0;
        chk("flushreq_busy", 32'(dif.div_busy), 32'd0);

        // Stall in DONE with noisy inputs during CALC
        run_chk("stall", 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_rdy", 32'(dif.div_ready_go), 32'd1);
            chk("stall_quot", dif.div_quot, 32'h0FFF_FFFF);
            chk("stall_rem", dif.div_rem, 32'hF);
        end
        fire_idle("stall");

        // Back-to-back: fire and req together -> one bubble
        run_chk("b2b_a", 1'b0, 32'd100, 32'd7, 1'b0);
        dif.es_fire  = 1'b1;
        dif.div_req  = 1'b1;
        dif.div_src1 = 32'd20;
        dif.div_src2 = 32'd3;
        tick();
        dif.es_fire = 1'b0;
        chk("b2b_bub_busy", 32'(dif.div_busy), 32'd0);
        chk("b2b_bub_rdy", 32'(dif.div_ready_go), 32'd0);
        tick();
        dif.div_req = 1'b0;
        chk("b2b_busy", 32'(dif.div_busy), 32'd1);
        wait_done(1'b0, lat);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_quot", dif.div_quot, 32'd6);
        chk("b2b_rem", dif.div_rem, 32'd2);
        fire_idle("b2b");

        // Reset at cycle 20 of CALC
        issue(1'b1, 32'hFFFF_FC18, 32'd7);
        for (int c = 1; c < 20; c++) tick();
        chk("mid_busy_pre", 32'(dif.div_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(dif.div_busy), 32'd0);
        chk("mid_rst_rdy", 32'(dif.div_ready_go), 32'd0);
        chk("mid_rst_quot", dif.div_quot, 32'd0);
        chk("mid_rst_rem", dif.div_rem, 32'd0);

        // Random operands with noisy inputs during CALC
        for (int i = 0; i < 40; i++) begin
            sgn  = 1'($urandom);
            a    = $urandom;
            pick = $urandom_range(0, 7);
            if (pick == 0)      b = 32'd0;
            else if (pick == 1) b = 32'($urandom_range(1, 15));
            else if (pick == 2) b = -32'($urandom_range(1, 15));
            else if (pick == 3) b = 32'hFFFF_FFFF;
            else                b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_chk($sformatf("rnd%0d", i), sgn, a, b, 1'b1);
            fire_idle($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_div_ctrl.md
Name: exe_div_ctrl

Overview:
Multi-cycle divide sequencer for the EXE stage. It latches DIV/DIVU operands from the stage datapath and runs a radix-2 restoring division, one quotient bit per cycle. While the division is in flight it holds the stage's ready_go low, then presents quotient and remainder until the stage hands the instruction to MEM. It also handles stage flush, divide-by-zero and signed corner cases.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, step-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
div_req  input  1  level; EXE holds a valid DIV/DIVU; sampled only in IDLE
div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_req
div_src1  input  WIDTH  dividend (rs value); sampled with div_req
div_src2  input  WIDTH  divisor (rt value); sampled with div_req
es_fire  input  1  EXE instruction accepted by MEM this cycle (es_to_ms_valid && ms_allowin)
es_flush  input  1  cancel in-flight divide; highest priority
div_busy  output  1  state is CALC
div_ready_go  output  1  state is DONE; EXE ORs this into es_ready_go for divide instructions
div_quot  output  WIDTH  signed-corrected quotient; valid while div_ready_go
div_rem  output  WIDTH  signed-corrected remainder; valid while div_ready_go

Behaviour:
- Reset: state=IDLE, count=0, internal registers 0. Outputs div_busy=0, div_ready_go=0, div_quot=0, div_rem=0.
- States: IDLE, CALC, DONE. One-hot or binary encoding is allowed; constants come from the package.
- IDLE, with div_req=1 and es_flush=0:
  - latch abs(src1) and abs(src2); abs applies only if div_signed and the operand MSB=1
  - latch q_neg = signed & (src1[MSB] ^ src2[MSB]) and r_neg = signed & src1[MSB]
  - partial remainder=0, count=0
  - if |abs(src2)|==0 (divide-by-zero), go to DONE directly; otherwise go to CALC.
- CALC, each cycle:
  - {rem, dvd} <<= 1; if rem >= divisor, then rem -= divisor and dvd[0]=1
  - count++
  - after the step with count==WIDTH-1, go to DONE
- Latency: req sampled in cycle 0; CALC covers cycles 1..WIDTH; div_ready_go=1 from cycle WIDTH+1 (33 for WIDTH=32).
- DONE:
  - div_quot = q_neg ? -dvd : dvd
  - div_rem = r_neg ? -rem : rem
  - both are registered and stable for the whole DONE period
  - stay in DONE until es_fire=1, then go to IDLE
- Divide-by-zero: result is div_quot = all-ones, div_rem = src1 raw, independent of signedness. ready_go is asserted in cycle 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): div_quot = 0x80000000, div_rem = 0. This falls out of the natural wrap of abs/negate; no special path.
- es_flush in any state: next state IDLE; outputs drop next cycle; no result is produced. If es_flush and div_req are both set in IDLE, the request is ignored.
- div_req outside IDLE is ignored; operands are not re-sampled. Operand changes during CALC have no effect.
- es_fire and div_req in the same DONE cycle: go to IDLE, and a new request is accepted one cycle later (minimum one bubble cycle between divides).
- es_fire outside DONE is ignored.
- reset mid-CALC: same as reset; takes priority over es_flush.

Decomposition:
- mycpu.h gets:
  - DIV_ST_IDLE / DIV_ST_CALC / DIV_ST_DONE encodings
  - DIV_STEPS (=32)
  - a DIV_OP bus field for the DS->ES bus (div, signed), so DS can mark divide instructions
- One sub-module, div_step: a combinational single restoring step. It takes rem, dvd and divisor, and returns the next rem and dvd. The controller instantiates it once.

Test Plan:
- DIVU 100/7, fire immediately at done -> div_ready_go first high at cycle 33; quot=14, rem=2; back in IDLE at cycle 34.
- DIV -7/2 (0xFFFFFFF9/0x2) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; DIV 7/-2 -> quot=0xFFFFFFFD, rem=1.
- DIVU 0x1234/0 -> ready_go at cycle 1; quot=0xFFFFFFFF, rem=0x1234; DIV 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0 at cycle 33.
- DIVU 50/5 with es_flush pulsed at cycle 10 -> IDLE at cycle 11, ready_go never asserts; new DIVU 9/4 issued at cycle 12 -> quot=2, rem=1 at cycle 45.
- DIVU 0xFFFFFFFF/0x10 with es_fire held low 5 cycles after done -> quot=0x0FFFFFFF, rem=0xF held stable cycles 33-38; operand inputs toggled randomly during CALC change nothing.
- Back-to-back: es_fire with div_req=1 in DONE -> one IDLE cycle, then the new request is sampled; reset asserted at cycle 20 of CALC -> all outputs 0 next cycle.
